// File: rtl/mpu_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the RS encoder input.
// Every frame leaving on m_axis is exactly FRAME_LEN bytes with last on the
// final byte. Short messages are padded with PAD_BYTE. Overlong messages are
// cut at FRAME_LEN, and their remaining bytes are drained from the source.
module mpu_frame_arbiter #(
  parameter int         NUM_SRC   = 4,
  parameter int         FRAME_LEN = 223,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_SRC-1:0]         s_axis_valid,
  output logic [NUM_SRC-1:0]         s_axis_ready,
  input  logic [8*NUM_SRC-1:0]       s_axis_data,
  input  logic [NUM_SRC-1:0]         s_axis_last,
  output logic                       m_axis_valid,
  input  logic                       m_axis_ready,
  output logic [7:0]                 m_axis_data,
  output logic                       m_axis_last,
  output logic [$clog2(NUM_SRC)-1:0] m_axis_src,
  output logic                       short_err,
  output logic                       long_err,
  output logic [31:0]                frame_cnt
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [SRC_W-1:0] RR_INIT  = SRC_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_PAD,
    S_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [SRC_W-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              short_err_q, short_err_d;
  logic              long_err_q, long_err_d;

  logic [SRC_W-1:0]  pick;
  logic              pick_vld;
  logic [SRC_W-1:0]  cand;

  logic              sel_valid;
  logic              sel_last;
  logic [7:0]        sel_data;
  logic              at_last;

  assign sel_valid = s_axis_valid[grant_q];
  assign sel_last  = s_axis_last[grant_q];
  assign sel_data  = s_axis_data[{grant_q, 3'b000} +: 8];
  assign at_last   = (byte_cnt_q == LAST_IDX);

  assign m_axis_src = grant_q;
  assign short_err  = short_err_q;
  assign long_err   = long_err_q;
  assign frame_cnt  = frame_cnt_q;

  // Round-robin search: first requester strictly after the last granted ID.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = SRC_W'((int'(rr_ptr_q) + i) % NUM_SRC);
      if (!pick_vld && s_axis_valid[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Next-state, counters and stream outputs; m_axis_valid never depends on m_axis_ready.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    short_err_d  = 1'b0;
    long_err_d   = 1'b0;
    m_axis_valid = 1'b0;
    m_axis_data  = 8'h00;
    m_axis_last  = 1'b0;
    s_axis_ready = '0;

    case (state_q)
      S_IDLE: begin
        if (enable && pick_vld) begin
          grant_d    = pick;
          rr_ptr_d   = pick;
          byte_cnt_d = '0;
          state_d    = S_PASS;
        end
      end

      S_PASS: begin
        m_axis_valid          = sel_valid;
        m_axis_data           = sel_data;
        m_axis_last           = at_last;
        s_axis_ready[grant_q] = m_axis_ready;
        if (sel_valid && m_axis_ready) begin
          if (!at_last) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (sel_last) begin
              short_err_d = 1'b1;
              state_d     = S_PAD;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            byte_cnt_d  = '0;
            if (sel_last) begin
              state_d = S_IDLE;
            end else begin
              long_err_d = 1'b1;
              state_d    = S_DROP;
            end
          end
        end
      end

      S_PAD: begin
        m_axis_valid = 1'b1;
        m_axis_data  = PAD_BYTE;
        m_axis_last  = at_last;
        if (m_axis_ready) begin
          if (at_last) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            byte_cnt_d  = '0;
            state_d     = S_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_DROP: begin
        // Tail bytes are accepted and discarded until the source ends its message.
        s_axis_ready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= RR_INIT;
      byte_cnt_q  <= '0;
      frame_cnt_q <= 32'd0;
      short_err_q <= 1'b0;
      long_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      short_err_q <= short_err_d;
      long_err_q  <= long_err_d;
    end
  end

endmodule

// File: tb/tb_mpu_frame_arbiter.sv
// Self-checking bench for mpu_frame_arbiter (NUM_SRC=4, FRAME_LEN=223).
// Source drivers pull bytes from per-source queues; every output byte is
// compared against a scoreboard filled when each message is queued.
module tb_mpu_frame_arbiter;

  localparam int         NSRC = 4;
  localparam int         FLEN = 223;
  localparam logic [7:0] PAD  = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  s_axis_valid;
  logic [3:0]  s_axis_ready;
  logic [31:0] s_axis_data;
  logic [3:0]  s_axis_last;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic [7:0]  m_axis_data;
  logic        m_axis_last;
  logic [1:0]  m_axis_src;
  logic        short_err;
  logic        long_err;
  logic [31:0] frame_cnt;

  mpu_frame_arbiter #(.NUM_SRC(NSRC), .FRAME_LEN(FLEN), .PAD_BYTE(PAD)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
    .m_axis_src(m_axis_src), .short_err(short_err), .long_err(long_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          fails     = 0;
  logic [10:0] sb[$];              // {src, last, data}
  logic [8:0]  srcq[NSRC][$];      // {last, data}
  logic [3:0]  hs_q = '0;
  int          cyc = 0;
  int          out_idx = 0;
  int          n_short = 0;
  int          n_long = 0;
  bit          activity = 1'b0;
  int          frame_starts[$];
  bit          rand_ready = 1'b0;
  int          vprob = 100;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_out = '0;

  // Monitor: sampled on the falling edge, between active edges.
  initial begin
    logic [10:0] got;
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      hs_q = s_axis_valid & s_axis_ready;
      if (short_err) n_short++;
      if (long_err) n_long++;
      if (m_axis_valid || (s_axis_ready != 4'b0)) activity = 1'b1;
      got = {m_axis_src, m_axis_last, m_axis_data};
      if (rst) prev_stall = 1'b0;
      if (prev_stall) begin
        tests_run++;
        if (!m_axis_valid || got !== prev_out) begin
          fails++;
          $display("FAIL stall_hold: cyc=%0d valid=%b out=%h, required valid=1 out=%h", cyc, m_axis_valid, got, prev_out);
        end
      end
      prev_stall = m_axis_valid && !m_axis_ready;
      prev_out   = got;
      if (m_axis_valid && m_axis_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL out_byte: cyc=%0d unexpected output %h, scoreboard empty", cyc, got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL out_byte: cyc=%0d idx=%0d got {src,last,data}=%h required %h", cyc, out_idx, got, exp);
          end
        end
        if (out_idx == 0) frame_starts.push_back(cyc);
        out_idx = m_axis_last ? 0 : out_idx + 1;
      end
    end
  end

  // Source and sink drivers, updated just after each rising edge.
  initial begin
    logic [8:0] tmp;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NSRC; i++) begin
        if (hs_q[i] && srcq[i].size() > 0) tmp = srcq[i].pop_front();
        if (!(s_axis_valid[i] && !hs_q[i]))
          s_axis_valid[i] = (srcq[i].size() > 0) && (int'($urandom_range(99)) < vprob);
        if (srcq[i].size() > 0) begin
          s_axis_data[8*i +: 8] = srcq[i][0][7:0];
          s_axis_last[i]        = srcq[i][0][8];
        end else begin
          s_axis_valid[i]       = 1'b0;
          s_axis_data[8*i +: 8] = 8'h00;
          s_axis_last[i]        = 1'b0;
        end
      end
      hs_q = '0;
      m_axis_ready = rand_ready ? (int'($urandom_range(99)) < 87) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Queue one message of len bytes on source s and the frame it must produce.
  task automatic send_frame(input int s, input int len, input int seed);
    logic [7:0] d;
    for (int k = 0; k < len; k++) srcq[s].push_back({(k == len - 1), 8'(seed + k)});
    for (int k = 0; k < FLEN; k++) begin
      d = (k < len) ? 8'(seed + k) : PAD;
      sb.push_back({2'(s), (k == FLEN - 1), d});
    end
  endtask

  task automatic flush();
    sb.delete();
    for (int i = 0; i < NSRC; i++) srcq[i].delete();
    s_axis_valid = '0;
    s_axis_last  = '0;
    s_axis_data  = '0;
    out_idx      = 0;
    prev_stall   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    n_short = 0;
    n_long  = 0;
  endtask

  function automatic bit busy();
    bit b = (sb.size() > 0);
    for (int i = 0; i < NSRC; i++) if (srcq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input int budget, output bit timed_out);
    int n = 0;
    while (busy() && n < budget) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= budget);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idx(input int target, output bit timed_out);
    int n = 0;
    while (out_idx < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 2000);
  endtask

  task automatic test_reset();
    s_axis_valid = 4'hF;
    #2;
    tests_run++;
    if ({s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, m_axis_src, short_err, long_err} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b valid=%b last=%b data=%h src=%0d serr=%b lerr=%b, required all 0",
               s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, m_axis_src, short_err, long_err);
    end
    tests_run++;
    if (frame_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
    s_axis_valid = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    send_frame(0, FLEN, 0);
    wait_drain(1000, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL single_drain: pending=%0d required 0", sb.size()); end
    tests_run++;
    if (frame_cnt !== 32'd1) begin fails++; $display("FAIL single_frame_cnt: got %0d required 1", frame_cnt); end
    tests_run++;
    if (n_short != 0 || n_long != 0) begin
      fails++;
      $display("FAIL single_err: got short=%0d long=%0d required 0 0", n_short, n_long);
    end
  endtask

  task automatic test_round_robin();
    bit to;
    do_reset();
    frame_starts.delete();
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < NSRC; s++) send_frame(s, FLEN, s * 40 + f * 7);
    wait_drain(4000, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL rr_drain: pending=%0d required 0", sb.size()); end
    tests_run++;
    if (frame_cnt !== 32'd8) begin fails++; $display("FAIL rr_frame_cnt: got %0d required 8", frame_cnt); end
    tests_run++;
    if (frame_starts.size() != 8) begin
      fails++;
      $display("FAIL rr_frames: got %0d frame starts required 8", frame_starts.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        tests_run++;
        if (frame_starts[i] - frame_starts[i-1] != FLEN + 1) begin
          fails++;
          $display("FAIL rr_gap: frame %0d spacing %0d cycles required %0d", i, frame_starts[i] - frame_starts[i-1], FLEN + 1);
        end
      end
    end
  endtask

  task automatic test_short();
    bit to;
    do_reset();
    send_frame(2, 100, 8'h30);
    wait_drain(1000, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL short_drain: pending=%0d required 0", sb.size()); end
    tests_run++;
    if (n_short != 1 || n_long != 0) begin
      fails++;
      $display("FAIL short_err: got short=%0d long=%0d required 1 0", n_short, n_long);
    end
    tests_run++;
    if (frame_cnt !== 32'd1) begin fails++; $display("FAIL short_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_long();
    bit to;
    do_reset();
    send_frame(1, 300, 5);
    repeat (10) @(negedge clk);
    // Source 2 follows source 1 in round-robin order, ahead of source 0.
    send_frame(2, FLEN, 8'h50);
    send_frame(0, FLEN, 8'h90);
    wait_drain(3000, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL long_drain: pending=%0d required 0", sb.size()); end
    tests_run++;
    if (n_long != 1 || n_short != 0) begin
      fails++;
      $display("FAIL long_err: got long=%0d short=%0d required 1 0", n_long, n_short);
    end
    tests_run++;
    if (frame_cnt !== 32'd3) begin fails++; $display("FAIL long_frame_cnt: got %0d required 3", frame_cnt); end
  endtask

  task automatic test_random();
    bit to;
    int s, mode, len, exp_short, exp_long;
    do_reset();
    rand_ready = 1'b1;
    vprob      = 75;
    exp_short  = 0;
    exp_long   = 0;
    for (int f = 0; f < 20; f++) begin
      s    = int'($urandom_range(3));
      mode = int'($urandom_range(2));
      len  = (mode == 0) ? FLEN : (mode == 1) ? int'($urandom_range(FLEN - 1, 1)) : int'($urandom_range(300, FLEN + 1));
      if (len < FLEN) exp_short++;
      if (len > FLEN) exp_long++;
      send_frame(s, len, int'($urandom_range(255)));
      wait_drain(3000, to);
      tests_run++;
      if (to) begin fails++; $display("FAIL random_drain: frame %0d pending=%0d required 0", f, sb.size()); end
    end
    tests_run++;
    if (n_short != exp_short || n_long != exp_long) begin
      fails++;
      $display("FAIL random_err: got short=%0d long=%0d required %0d %0d", n_short, n_long, exp_short, exp_long);
    end
    tests_run++;
    if (frame_cnt !== 32'd20) begin fails++; $display("FAIL random_frame_cnt: got %0d required 20", frame_cnt); end
    rand_ready = 1'b0;
    vprob      = 100;
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    send_frame(0, FLEN, 8'h11);
    wait_idx(50, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL midrst_start: out_idx=%0d required 50", out_idx); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, m_axis_src, short_err, long_err} !== 17'd0 || frame_cnt !== 32'd0) begin
      fails++;
      $display("FAIL midrst_outputs: got valid=%b data=%h src=%0d ready=%b frame_cnt=%0d, required all 0",
               m_axis_valid, m_axis_data, m_axis_src, s_axis_ready, frame_cnt);
    end
    flush();
    repeat (3) @(negedge clk);
    tests_run++;
    if (m_axis_valid !== 1'b0 || s_axis_ready !== 4'b0) begin
      fails++;
      $display("FAIL midrst_hold: got valid=%b ready=%b, required 0 0", m_axis_valid, s_axis_ready);
    end
    @(posedge clk); #3 rst = 1'b0;
    n_short = 0;
    n_long  = 0;
    // Both request together: the reset pointer must hand source 0 the first grant.
    send_frame(0, FLEN, 8'h77);
    send_frame(1, FLEN, 8'hA0);
    wait_idx(100, to);
    tests_run++;
    if (to || frame_cnt !== 32'd0) begin
      fails++;
      $display("FAIL midrst_cnt_before: got frame_cnt=%0d required 0", frame_cnt);
    end
    wait_drain(2000, to);
    tests_run++;
    if (to || frame_cnt !== 32'd2) begin
      fails++;
      $display("FAIL midrst_cnt_after: got frame_cnt=%0d pending=%0d required 2 and 0", frame_cnt, sb.size());
    end
  endtask

  task automatic test_enable();
    bit to;
    do_reset();
    enable = 1'b0;
    send_frame(3, FLEN, 8'h22);
    activity = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (activity) begin fails++; $display("FAIL enable_block: got grant activity=1 required 0"); end
    enable = 1'b1;
    wait_idx(10, to);
    enable = 1'b0;
    wait_drain(1000, to);
    tests_run++;
    if (to || frame_cnt !== 32'd1) begin
      fails++;
      $display("FAIL enable_midframe: got frame_cnt=%0d pending=%0d required 1 and 0", frame_cnt, sb.size());
    end
    enable = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    s_axis_valid = '0;
    s_axis_data  = '0;
    s_axis_last  = '0;
    m_axis_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_short();
    test_long();
    test_random();
    test_reset_mid_frame();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
